reset_sequencer: RTL and testbench

RESET_SEQUENCER -- requirements
Module: reset_sequencer

---
 rtl/reset_sequencer_pkg.sv | 21 ++
 rtl/sync_2ff.sv | 24 ++
 rtl/reset_sequencer.sv | 139 +++++++++++++
 tb/tb_reset_sequencer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/reset_sequencer_pkg.sv
// Shared types for the reset sequencer: FSM states, hold severity and reason bit positions.
// Types only; no logic, no latency, no flow control.
package reset_sequencer_pkg;

    typedef enum logic [1:0] {
        S_POR  = 2'd0,
        S_HOLD = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    typedef enum logic {
        HOLD_FULL     = 1'b0,
        HOLD_NDM_ONLY = 1'b1
    } hold_t;

    localparam int RSN_POR = 0;
    localparam int RSN_EXT = 1;
    localparam int RSN_NDM = 2;
    localparam int RSN_SW  = 3;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous level; 2 cycle latency.
// No backpressure; output is a plain level that follows d.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/reset_sequencer.sv
// Sequences debug / SoC resets from POR, PLL lock, button, debug and software causes; outputs registered, 1 cycle after a cause is sampled.
// No backpressure: requests are single-cycle pulses that are always accepted.
module reset_sequencer
    import reset_sequencer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int HOLD_CYCLES     = 32
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       ext_rst_n_raw,
    input  logic       pll_locked,
    input  logic       ndm_reset_req,
    input  logic       sw_reset_req,
    input  logic       reason_clr,
    output logic       dm_rst_o,
    output logic       ndm_rst_o,
    output logic [3:0] reason_o
);

    localparam logic [15:0] DEB_MAX     = 16'(DEBOUNCE_CYCLES);
    localparam logic [15:0] HOLD_RELOAD = 16'(HOLD_CYCLES - 1);

    logic        ext_sync;
    logic        pll_sync;
    logic [15:0] deb_cnt;
    logic        ext_req;
    logic        req_any;

    state_t      state_q, state_d;
    hold_t       hold_q, hold_d;
    logic [15:0] hold_cnt_q, hold_cnt_d;
    logic [3:0]  rsn_set;
    logic [3:0]  reason_d;
    logic        dm_rst_d;
    logic        ndm_rst_d;

    sync_2ff #(.RESET_VAL(1'b1)) u_sync_ext (
        .clk (sys_clk),
        .rst (rst),
        .d   (ext_rst_n_raw),
        .q   (ext_sync)
    );

    sync_2ff #(.RESET_VAL(1'b0)) u_sync_pll (
        .clk (sys_clk),
        .rst (rst),
        .d   (pll_locked),
        .q   (pll_sync)
    );

    // Saturating low-run counter: a press is recognised only after an unbroken low run.
    always_ff @(posedge sys_clk) begin
        if (rst || ext_sync) begin
            deb_cnt <= 16'd0;
        end else if (deb_cnt != DEB_MAX) begin
            deb_cnt <= deb_cnt + 16'd1;
        end
    end

    assign ext_req = (deb_cnt == DEB_MAX);
    assign req_any = ext_req | ndm_reset_req | sw_reset_req;

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q    <= S_POR;
            hold_q     <= HOLD_FULL;
            hold_cnt_q <= 16'd0;
            dm_rst_o   <= 1'b1;
            ndm_rst_o  <= 1'b1;
            reason_o   <= 4'b0001;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            hold_cnt_q <= hold_cnt_d;
            dm_rst_o   <= dm_rst_d;
            ndm_rst_o  <= ndm_rst_d;
            reason_o   <= reason_d;
        end
    end

    // Loss of lock beats every other event; a button cause always forces FULL.
    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        hold_cnt_d = hold_cnt_q;
        rsn_set    = 4'b0000;
        if (!pll_sync) begin
            state_d    = S_POR;
            hold_d     = HOLD_FULL;
            hold_cnt_d = 16'd0;
        end else begin
            case (state_q)
                S_POR: begin
                    state_d          = S_HOLD;
                    hold_d           = HOLD_FULL;
                    hold_cnt_d       = HOLD_RELOAD;
                    rsn_set[RSN_POR] = 1'b1;
                end
                S_HOLD: begin
                    if (req_any) begin
                        hold_cnt_d = HOLD_RELOAD;
                        if (ext_req) begin
                            hold_d = HOLD_FULL;
                        end
                    end else if (hold_cnt_q == 16'd0) begin
                        state_d = S_RUN;
                    end else begin
                        hold_cnt_d = hold_cnt_q - 16'd1;
                    end
                    rsn_set[RSN_EXT] = ext_req;
                    rsn_set[RSN_NDM] = ndm_reset_req;
                    rsn_set[RSN_SW]  = sw_reset_req;
                end
                S_RUN: begin
                    if (req_any) begin
                        state_d    = S_HOLD;
                        hold_d     = ext_req ? HOLD_FULL : HOLD_NDM_ONLY;
                        hold_cnt_d = HOLD_RELOAD;
                    end
                    rsn_set[RSN_EXT] = ext_req;
                    rsn_set[RSN_NDM] = ndm_reset_req;
                    rsn_set[RSN_SW]  = sw_reset_req;
                end
                default: begin
                    state_d = S_POR;
                end
            endcase
        end
    end

    // Outputs decode the next state so they register in step with it.
    always_comb begin
        dm_rst_d  = (state_d == S_POR) || ((state_d == S_HOLD) && (hold_d == HOLD_FULL));
        ndm_rst_d = (state_d != S_RUN);
        reason_d  = (reason_clr ? 4'b0000 : reason_o) | rsn_set;
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: vector table, directed corner sequences, then random traffic against a reference model.
// Reference model tracks remaining hold cycles and raw low-run length rather than FSM states.
module tb_reset_sequencer;

    localparam int DEB  = 4;
    localparam int HOLD = 8;

    logic       sys_clk = 1'b0;
    logic       rst = 1'b1;
    logic       ext_rst_n_raw = 1'b1;
    logic       pll_locked = 1'b1;
    logic       ndm_reset_req = 1'b0;
    logic       sw_reset_req = 1'b0;
    logic       reason_clr = 1'b0;
    logic       dm_rst_o;
    logic       ndm_rst_o;
    logic [3:0] reason_o;

    reset_sequencer #(
        .DEBOUNCE_CYCLES (DEB),
        .HOLD_CYCLES     (HOLD)
    ) dut (
        .sys_clk       (sys_clk),
        .rst           (rst),
        .ext_rst_n_raw (ext_rst_n_raw),
        .pll_locked    (pll_locked),
        .ndm_reset_req (ndm_reset_req),
        .sw_reset_req  (sw_reset_req),
        .reason_clr    (reason_clr),
        .dm_rst_o      (dm_rst_o),
        .ndm_rst_o     (ndm_rst_o),
        .reason_o      (reason_o)
    );

    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int errors = 0;
    int cnt_dm = 0;
    int cnt_ndm = 0;

    typedef struct {
        logic       rst;
        logic       ext;
        logic       pll;
        logic       ndm;
        logic       sw;
        logic       clr;
        logic       e_dm;
        logic       e_ndm;
        logic [3:0] e_rsn;
    } vec_t;

    vec_t tbl[$];

    // Reference model state
    bit [1:0]   m_ext = 2'b11;
    bit [1:0]   m_pll = 2'b00;
    int         m_low = 0;
    int         m_left = 0;
    bit         m_por = 1'b1;
    bit         m_full = 1'b1;
    logic [3:0] m_rsn = 4'b0001;

    int ext_left = 0;

    function automatic void push(int n, logic r, logic e, logic p, logic nd, logic s, logic c,
                                 logic edm, logic endm, logic [3:0] ersn);
        vec_t v;
        v.rst = r; v.ext = e; v.pll = p; v.ndm = nd; v.sw = s; v.clr = c;
        v.e_dm = edm; v.e_ndm = endm; v.e_rsn = ersn;
        for (int i = 0; i < n; i++) tbl.push_back(v);
    endfunction

    task automatic chk(string name, logic [3:0] act, logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Advances the model across one rising edge using the inputs currently driven.
    task automatic model_edge();
        bit pll_s;
        bit ext_req;
        if (rst) begin
            m_ext = 2'b11; m_pll = 2'b00; m_low = 0; m_left = 0;
            m_por = 1'b1; m_full = 1'b1; m_rsn = 4'b0001;
            return;
        end
        pll_s   = m_pll[1];
        ext_req = (m_low >= DEB);
        if (reason_clr) m_rsn = 4'b0000;
        if (!pll_s) begin
            m_por = 1'b1; m_left = 0; m_full = 1'b1;
        end else if (m_por) begin
            m_por = 1'b0; m_left = HOLD; m_full = 1'b1; m_rsn[0] = 1'b1;
        end else if (ext_req || ndm_reset_req || sw_reset_req) begin
            m_full = ((m_left > 0) ? m_full : 1'b0) | ext_req;
            m_left = HOLD;
            if (ext_req)       m_rsn[1] = 1'b1;
            if (ndm_reset_req) m_rsn[2] = 1'b1;
            if (sw_reset_req)  m_rsn[3] = 1'b1;
        end else if (m_left > 0) begin
            m_left = m_left - 1;
        end
        m_low = m_ext[1] ? 0 : m_low + 1;
        m_ext = {m_ext[0], ext_rst_n_raw};
        m_pll = {m_pll[0], pll_locked};
    endtask

    task automatic tick();
        model_edge();
        @(posedge sys_clk);
        #1;
        if (dm_rst_o)  cnt_dm++;
        if (ndm_rst_o) cnt_ndm++;
    endtask

    task automatic check_model(string tag);
        logic e_ndm;
        logic e_dm;
        e_ndm = m_por || (m_left > 0);
        e_dm  = m_por || ((m_left > 0) && m_full);
        chk({tag, ".dm"},     {3'b000, dm_rst_o},  {3'b000, e_dm});
        chk({tag, ".ndm"},    {3'b000, ndm_rst_o}, {3'b000, e_ndm});
        chk({tag, ".reason"}, reason_o, m_rsn);
    endtask

    task automatic run(int n, string tag);
        for (int i = 0; i < n; i++) begin
            tick();
            check_model(tag);
        end
    endtask

    initial begin
        // Power-on, software reset, clear-vs-set and debug-module reset as a vector table.
        push(3,  1, 1, 1, 0, 0, 0, 1, 1, 4'b0001);
        push(10, 0, 1, 1, 0, 0, 0, 1, 1, 4'b0001);
        push(2,  0, 1, 1, 0, 0, 0, 0, 0, 4'b0001);
        push(1,  0, 1, 1, 0, 1, 0, 0, 1, 4'b1001);
        push(7,  0, 1, 1, 0, 0, 0, 0, 1, 4'b1001);
        push(2,  0, 1, 1, 0, 0, 0, 0, 0, 4'b1001);
        push(1,  0, 1, 1, 0, 1, 1, 0, 1, 4'b1000);
        push(7,  0, 1, 1, 0, 0, 0, 0, 1, 4'b1000);
        push(1,  0, 1, 1, 0, 0, 0, 0, 0, 4'b1000);
        push(1,  0, 1, 1, 0, 0, 1, 0, 0, 4'b0000);
        push(1,  0, 1, 1, 1, 0, 0, 0, 1, 4'b0100);
        push(7,  0, 1, 1, 0, 0, 0, 0, 1, 4'b0100);
        push(2,  0, 1, 1, 0, 0, 0, 0, 0, 4'b0100);

        foreach (tbl[i]) begin
            rst = tbl[i].rst; ext_rst_n_raw = tbl[i].ext; pll_locked = tbl[i].pll;
            ndm_reset_req = tbl[i].ndm; sw_reset_req = tbl[i].sw; reason_clr = tbl[i].clr;
            tick();
            chk($sformatf("tbl%0d.dm", i),  {3'b000, dm_rst_o},  {3'b000, tbl[i].e_dm});
            chk($sformatf("tbl%0d.ndm", i), {3'b000, ndm_rst_o}, {3'b000, tbl[i].e_ndm});
            chk($sformatf("tbl%0d.rsn", i), reason_o, tbl[i].e_rsn);
        end
        rst = 1'b0; ext_rst_n_raw = 1'b1; pll_locked = 1'b1;
        ndm_reset_req = 1'b0; sw_reset_req = 1'b0; reason_clr = 1'b0;

        // Short bounce must not reset; a long press holds until 2 sync + HOLD cycles after release.
        cnt_ndm = 0;
        ext_rst_n_raw = 1'b0; run(3, "bounce");
        ext_rst_n_raw = 1'b1; run(6, "bounce");
        chk("bounce_no_reset", 4'(cnt_ndm), 4'd0);
        cnt_dm = 0;
        ext_rst_n_raw = 1'b0; run(20, "press");
        chk("press_dm_cycles", 4'(cnt_dm), 4'd14);
        cnt_dm = 0; cnt_ndm = 0;
        ext_rst_n_raw = 1'b1; run(14, "release");
        chk("release_dm_cycles", 4'(cnt_dm), 4'd10);
        chk("release_ndm_cycles", 4'(cnt_ndm), 4'd10);
        chk("press_reason_ext", {3'b000, reason_o[1]}, 4'd1);

        // Debug-module request, then a button press seen 3 cycles into the hold: upgrade and reload.
        ext_rst_n_raw = 1'b0; run(3, "upg_pre");
        cnt_dm = 0; cnt_ndm = 0;
        ndm_reset_req = 1'b1; run(1, "upg");
        ndm_reset_req = 1'b0; ext_rst_n_raw = 1'b1;
        run(2, "upg");
        chk("upg_dm_before", {3'b000, dm_rst_o}, 4'd0);
        run(1, "upg");
        chk("upg_dm_after", {3'b000, dm_rst_o}, 4'd1);
        run(16, "upg");
        chk("upg_ndm_cycles", 4'(cnt_ndm), 4'd11);
        chk("upg_dm_cycles", 4'(cnt_dm), 4'd8);

        // PLL loss mid-hold forces POR within 3 cycles; relock gives a full hold.
        sw_reset_req = 1'b1; run(1, "pll");
        sw_reset_req = 1'b0; run(3, "pll");
        pll_locked = 1'b0; run(2, "pll");
        chk("pll_dm_before_por", {3'b000, dm_rst_o}, 4'd0);
        run(1, "pll");
        chk("pll_dm_in_por", {3'b000, dm_rst_o}, 4'd1);
        chk("pll_ndm_in_por", {3'b000, ndm_rst_o}, 4'd1);
        run(5, "pll");
        cnt_dm = 0; cnt_ndm = 0;
        pll_locked = 1'b1; run(14, "relock");
        chk("relock_dm_cycles", 4'(cnt_dm), 4'd10);
        chk("relock_ndm_cycles", 4'(cnt_ndm), 4'd10);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            if (pll_locked) pll_locked = ($urandom_range(0, 149) != 0);
            else            pll_locked = ($urandom_range(0, 5) == 0);
            if (ext_left == 0) begin
                if ($urandom_range(0, 2) == 0) begin
                    ext_rst_n_raw = 1'b0; ext_left = $urandom_range(1, 12);
                end else begin
                    ext_rst_n_raw = 1'b1; ext_left = $urandom_range(1, 30);
                end
            end
            ext_left--;
            ndm_reset_req = ($urandom_range(0, 24) == 0);
            sw_reset_req  = ($urandom_range(0, 24) == 0);
            reason_clr    = ($urandom_range(0, 29) == 0);
            run(1, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
